// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, EX branch
// redirects, and multi-cycle MEM accesses (BRAM latency, IO write handshake with timeout).
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_WAIT_CYCLES = 1,
  parameter int unsigned IO_TIMEOUT      = 255,
  parameter int unsigned CNT_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs1_addr,
  input  logic [4:0]  ID_rs2_addr,
  input  logic        ID_rs1_used,
  input  logic        ID_rs2_used,
  input  logic        EX_MemtoReg,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_rd_addr,
  input  logic        EX_branch_taken,
  input  logic        MEM_MemAccess,
  input  logic        MEM_ioWrite,
  input  logic        io_ready,
  output logic        io_req,
  output logic        pc_hold,
  output logic        IFID_hold,
  output logic        IDEX_hold,
  output logic        EXMEM_hold,
  output logic        IFID_flush,
  output logic        IDEX_flush,
  output logic        MEMWB_flush,
  output logic        io_err,
  output logic [31:0] stall_cnt
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] MEMWAIT = 2'd1;
  localparam logic [1:0] IOWAIT  = 2'd2;

  localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] IO_LOAD  = CNT_W'(IO_TIMEOUT - 1);

  logic [1:0]       state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             ioEv, memEv, cntZero, mstall, ioReqRaw, ioErrSet, lu, anyStall;

  always_comb begin
    ioEv      = MEM_ioWrite;
    memEv     = MEM_MemAccess & ~MEM_ioWrite & (MEM_WAIT_CYCLES != 0);
    cntZero   = (cnt == '0);
    mstall    = 1'b0;
    ioReqRaw  = 1'b0;
    ioErrSet  = 1'b0;
    stateNext = state;
    cntNext   = cnt;
    case (state)
      RUN: begin
        if (ioEv) begin
          ioReqRaw = 1'b1;
          if (!io_ready) begin
            mstall    = 1'b1;
            stateNext = IOWAIT;
            cntNext   = IO_LOAD;
          end
        end else if (memEv) begin
          mstall    = 1'b1;
          stateNext = MEMWAIT;
          cntNext   = MEM_LOAD;
        end
      end
      MEMWAIT: begin
        if (!cntZero) begin
          mstall  = 1'b1;
          cntNext = cnt - CNT_W'(1);
        end else begin
          stateNext = RUN;
        end
      end
      IOWAIT: begin
        ioReqRaw = 1'b1;
        if (io_ready) begin
          stateNext = RUN;
        end else if (!cntZero) begin
          mstall  = 1'b1;
          cntNext = cnt - CNT_W'(1);
        end else begin
          stateNext = RUN;
          ioErrSet  = 1'b1;
        end
      end
      default: stateNext = RUN;
    endcase

    lu = EX_MemtoReg & EX_RegWrite & (EX_rd_addr != 5'd0) &
         ((ID_rs1_used & (ID_rs1_addr == EX_rd_addr)) |
          (ID_rs2_used & (ID_rs2_addr == EX_rd_addr)));

    pc_hold     = 1'b0;
    IFID_hold   = 1'b0;
    IDEX_hold   = 1'b0;
    EXMEM_hold  = 1'b0;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    MEMWB_flush = 1'b0;
    io_req      = 1'b0;
    // A MEM stall freezes EX, so branch/load-use are deferred to the release cycle.
    if (!rst) begin
      io_req = ioReqRaw;
      if (mstall) begin
        pc_hold     = 1'b1;
        IFID_hold   = 1'b1;
        IDEX_hold   = 1'b1;
        EXMEM_hold  = 1'b1;
        MEMWB_flush = 1'b1;
      end else if (EX_branch_taken) begin
        IFID_flush = 1'b1;
        IDEX_flush = 1'b1;
      end else if (lu) begin
        pc_hold    = 1'b1;
        IFID_hold  = 1'b1;
        IDEX_flush = 1'b1;
      end
    end

    anyStall = pc_hold | IFID_hold | IDEX_hold | EXMEM_hold |
               IFID_flush | IDEX_flush | MEMWB_flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      io_err    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (ioErrSet) io_err <= 1'b1;
      if (anyStall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
